bus_sram_responder: RTL and testbench
=====================================

// Module: bus_sram_responder
// PURPOSE
//   Target-side model of the core's instruction and data buses: answers ibus_req_t / dbus_req_t
//   from the core with ibus_resp_t / dbus_resp_t, backed by one shared 64-bit word SRAM.
//   Sits under the core in the simulation top and in synthesis bring-up, replacing the external memory.
//   Gives a fixed (optionally randomised) multi-cycle latency so the core's stall logic is exercised.
// PARAMETERS
//   DEPTH      4096        number of 64-bit words; power of two
//   LATENCY    2           cycles from acceptance to data_ok; legal range 1..15
//   LFSR_SEED  16'hACE1    reset seed of the stall-injection LFSR (used only with MEM_STALL_INJECT_EN)
// PORTS
//   clk     in   1               clock
//   reset   in   1               synchronous, active-high
//   ireq    in   ibus_req_t      {valid, addr[63:0]}
//   iresp   out  ibus_resp_t     {addr_ok, data_ok, data[31:0]}
//   dreq    in   dbus_req_t      {valid, addr[63:0], size, strobe[7:0], data[63:0]}
//   dresp   out  dbus_resp_t     {addr_ok, data_ok, data[63:0]}
// BEHAVIOUR
//   - Reset: both channels IDLE; addr_ok = 0, data_ok = 0, data = 0; latency counters 0; LFSR = LFSR_SEED.
//     SRAM contents are not cleared. Reset mid-transaction aborts it: no data_ok and no write.
//   - Each channel runs an independent FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: when valid = 1, capture addr (and strobe/data for dbus). Load the counter with LATENCY-1 and go to WAIT.
//     If LATENCY = 1, go directly to RESP.
//   - WAIT: decrement the counter each cycle; go to RESP when the counter is 0.
//     Request inputs are ignored while in WAIT; the initiator holds them stable.
//   - RESP: addr_ok = data_ok = 1 for exactly one cycle, then IDLE.
//     If valid is still high in the cycle after RESP, it is a new request and is accepted.
//     Net throughput: one transaction per LATENCY+1 cycles per channel.
//   - Indexing: word index = addr[$clog2(DEPTH)+2:3]; higher address bits are ignored (wraps mod DEPTH).
//   - ibus data = addr[2] ? word[63:32] : word[31:0], read in the RESP cycle.
//   - dbus with strobe == 0 is a read: dresp.data = the full word, read in the RESP cycle.
//   - dbus with strobe != 0 is a write: on the RESP clock edge, bytes with strobe[i] = 1 take data[8i+7:8i];
//     dresp.data = 0. size is informational only; strobe is authoritative.
//   - Same word, same RESP cycle: an ibus or dbus read returns the pre-write value. The write lands at the clock edge.
//   - Both channels in RESP on the same cycle: both are served; the SRAM has one write port and two read ports.
//   - data outputs are 0 whenever data_ok = 0.
// CONFIGURATION
//   MEM_STALL_INJECT_EN defined:
//     - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
//     - On acceptance, the load value becomes LATENCY-1 + lfsr[1:0], adding 0..3 extra wait cycles per transaction.
//   MEM_STALL_INJECT_EN undefined:
//     - No LFSR is present; latency is exactly LATENCY.
// STRUCTURE
//   - common package (existing) holds ibus_req_t, ibus_resp_t, dbus_req_t, dbus_resp_t, u64, u32, u8, strobe_t.
//   - New constants go in the same package: RESP_LAT_W = 4, and enum resp_state_t {RS_IDLE, RS_WAIT, RS_RESP}.
//   - Sub-module resp_channel_fsm:
//       inputs: clk, reset, req_valid, lat_load[3:0]
//       outputs: accept, in_resp
//     Instantiated once for ibus and once for dbus. The top level owns the SRAM, capture registers and LFSR.
// TESTING
//   1 LATENCY=2: ireq.valid=1, addr=0x8000_0004, word0 = 64'h1111_2222_3333_4444
//       -> iresp.data_ok high on cycle 3 after the request (acceptance cycle + 2), data = 32'h1111_2222, then low.
//   2 dreq write: addr=0x10, strobe=8'h0F, data=64'hAAAA_BBBB_CCCC_DDDD over word2 = 64'h0
//       -> after data_ok, a read of 0x10 returns 64'h0000_0000_CCCC_DDDD.
//   3 ireq held valid continuously at LATENCY=1
//       -> data_ok pulses every 2nd cycle, never on consecutive cycles.
//   4 ibus read and dbus write of the same word complete on the same cycle
//       -> ibus returns the old value; a following ibus read returns the new value.
//   5 Assert reset during WAIT of a dbus write with strobe 8'hFF
//       -> no data_ok, the word is unchanged, and all outputs are 0 the cycle after reset.
//   6 With MEM_STALL_INJECT_EN: 1000 back-to-back reads
//       -> every acceptance-to-data_ok latency is in [LATENCY, LATENCY+3]; all data matches the model.

Source files
------------

// File: rtl/bus_sram_responder_pkg.sv
// Shared bus types and constants for the SRAM-backed bus responder.
// Holds the ibus/dbus request/response structs, the latency counter width,
// the response-channel state encoding and the byte-strobe merge helper.
package bus_sram_responder_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic [7:0]  u8;
  typedef logic [7:0]  strobe_t;
  typedef logic [2:0]  msize_t;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    u64      addr;
    msize_t  size;
    strobe_t strobe;
    u64      data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  // Width of the per-channel latency down-counter.
  localparam int RESP_LAT_W = 4;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_WAIT = 2'd1,
    RS_RESP = 2'd2
  } resp_state_t;

  // Merge write data into an existing word; only strobed bytes change.
  function automatic u64 apply_strobe(input u64 old_word, input u64 wdata, input strobe_t strb);
    u64 merged;
    merged = old_word;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/bus_sram_responder_fsm.sv
// Per-channel response sequencer: IDLE -> WAIT -> RESP -> IDLE.
// A request seen in IDLE is accepted and the latency counter is loaded with
// lat_load; a zero load skips WAIT. RESP lasts exactly one cycle.
module resp_channel_fsm
  import bus_sram_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [RESP_LAT_W-1:0] lat_load,
  output logic                  accept,
  output logic                  in_resp
);

  resp_state_t           state_q, state_d;
  logic [RESP_LAT_W-1:0] cnt_q, cnt_d;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; RESP is reached when the counter would hit zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RS_IDLE: begin
        if (req_valid) begin
          cnt_d = lat_load;
          if (lat_load == '0) begin
            state_d = RS_RESP;
          end else begin
            state_d = RS_WAIT;
          end
        end else begin
          state_d = RS_IDLE;
        end
      end
      RS_WAIT: begin
        if (cnt_q <= RESP_LAT_W'(1)) begin
          cnt_d   = '0;
          state_d = RS_RESP;
        end else begin
          cnt_d   = cnt_q - RESP_LAT_W'(1);
          state_d = RS_WAIT;
        end
      end
      RS_RESP: begin
        cnt_d   = '0;
        state_d = RS_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RS_IDLE;
      end
    endcase
  end

  // Decoded outputs: acceptance strobe and one-cycle response flag.
  always_comb begin
    accept  = (state_q == RS_IDLE) && req_valid;
    in_resp = (state_q == RS_RESP);
  end

endmodule

// File: rtl/bus_sram_responder.sv
// Target-side responder for the core's ibus and dbus, backed by one shared
// 64-bit word SRAM (one write port, two read ports).
// Optional MEM_STALL_INJECT_EN: a 16-bit LFSR adds 0..3 random wait cycles
// to every accepted transaction; without it latency is exactly LATENCY.
module bus_sram_responder
  import bus_sram_responder_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int                    AW       = $clog2(DEPTH);
  localparam logic [RESP_LAT_W-1:0] LAT_BASE = RESP_LAT_W'(LATENCY - 1);

  logic                  i_accept, i_in_resp;
  logic                  d_accept, d_in_resp;
  logic [RESP_LAT_W-1:0] lat_load;

  logic [AW-1:0] iidx_q;
  logic          ihi_q;
  logic [AW-1:0] didx_q;
  strobe_t       dstrb_q;
  u64            ddata_q;

  u64   mem_q [DEPTH];
  u64   iword, dword;
  logic wr_en;
  logic unused_bits;

`ifdef MEM_STALL_INJECT_EN
  logic [15:0]         lfsr_q, lfsr_d;
  logic [RESP_LAT_W:0] lat_sum;

  // Fibonacci LFSR next value, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR free-runs every cycle from the reset seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Random extra wait; saturate so large LATENCY values cannot wrap the counter.
  always_comb begin
    lat_sum = {1'b0, LAT_BASE} + {{(RESP_LAT_W-1){1'b0}}, lfsr_q[1:0]};
    if (lat_sum[RESP_LAT_W]) begin
      lat_load = '1;
    end else begin
      lat_load = lat_sum[RESP_LAT_W-1:0];
    end
  end

  assign unused_bits = ^{ireq.addr[63:AW+3], ireq.addr[1:0],
                         dreq.addr[63:AW+3], dreq.addr[2:0], dreq.size};
`else
  // Fixed latency load.
  always_comb begin
    lat_load = LAT_BASE;
  end

  assign unused_bits = ^{ireq.addr[63:AW+3], ireq.addr[1:0],
                         dreq.addr[63:AW+3], dreq.addr[2:0], dreq.size, LFSR_SEED};
`endif

  resp_channel_fsm u_ifsm (
    .clk       (clk),
    .reset     (reset),
    .req_valid (ireq.valid),
    .lat_load  (lat_load),
    .accept    (i_accept),
    .in_resp   (i_in_resp)
  );

  resp_channel_fsm u_dfsm (
    .clk       (clk),
    .reset     (reset),
    .req_valid (dreq.valid),
    .lat_load  (lat_load),
    .accept    (d_accept),
    .in_resp   (d_in_resp)
  );

  // Capture ibus request fields on acceptance; held through WAIT/RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      iidx_q <= '0;
      ihi_q  <= 1'b0;
    end else if (i_accept) begin
      iidx_q <= ireq.addr[AW+2:3];
      ihi_q  <= ireq.addr[2];
    end
  end

  // Capture dbus request fields on acceptance; held through WAIT/RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      didx_q  <= '0;
      dstrb_q <= 8'h00;
      ddata_q <= 64'h0;
    end else if (d_accept) begin
      didx_q  <= dreq.addr[AW+2:3];
      dstrb_q <= dreq.strobe;
      ddata_q <= dreq.data;
    end
  end

  // A reset in the RESP cycle must abort the write as well.
  assign wr_en = d_in_resp && (dstrb_q != 8'h00) && !reset;

  // SRAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[didx_q] <= apply_strobe(mem_q[didx_q], ddata_q, dstrb_q);
    end
  end

  // Asynchronous read ports: a same-cycle write is still pending, so reads see the old word.
  always_comb begin
    iword = mem_q[iidx_q];
    dword = mem_q[didx_q];
  end

  // Response outputs; data is forced to zero whenever data_ok is low.
  always_comb begin
    iresp         = '0;
    dresp         = '0;
    iresp.addr_ok = i_in_resp;
    iresp.data_ok = i_in_resp;
    dresp.addr_ok = d_in_resp;
    dresp.data_ok = d_in_resp;
    if (i_in_resp) begin
      iresp.data = ihi_q ? iword[63:32] : iword[31:0];
    end else begin
      iresp.data = 32'h0;
    end
    if (d_in_resp && (dstrb_q == 8'h00)) begin
      dresp.data = dword;
    end else begin
      dresp.data = 64'h0;
    end
  end

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed self-checking bench for bus_sram_responder (LATENCY=2 main
// instance, LATENCY=1 instance for back-to-back throughput).
module tb_bus_sram_responder;
  import bus_sram_responder_pkg::*;

  localparam int LAT = 2;

  logic       clk;
  logic       reset;
  ibus_req_t  ireq,  ireq1;
  ibus_resp_t iresp, iresp1;
  dbus_req_t  dreq,  dreq1;
  dbus_resp_t dresp, dresp1;

  int n_checks = 0;
  int n_errors = 0;

  bus_sram_responder #(.DEPTH(4096), .LATENCY(LAT), .LFSR_SEED(16'hACE1)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp)
  );

  bus_sram_responder #(.DEPTH(4096), .LATENCY(1), .LFSR_SEED(16'hACE1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq1),
    .iresp (iresp1),
    .dreq  (dreq1),
    .dresp (dresp1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ibus read starting in an IDLE cycle; returns at the data_ok negedge, valid left high.
  task automatic ird(input logic [63:0] addr, output logic [31:0] data, output int lat);
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = addr;
    lat  = 99;
    data = 32'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (iresp.data_ok) begin
        lat  = k;
        data = iresp.data;
        break;
      end
    end
  endtask

  // dbus transaction; returns at the data_ok negedge, valid left high.
  task automatic dtx(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] wdata,
                     output logic [63:0] rdata, output int lat);
    @(negedge clk);
    dreq.valid  = 1'b1;
    dreq.addr   = addr;
    dreq.size   = 3'd3;
    dreq.strobe = strb;
    dreq.data   = wdata;
    lat   = 99;
    rdata = 64'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dresp.data_ok) begin
        lat   = k;
        rdata = dresp.data;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] d32;
    logic [63:0] d64;
    int          lat;
    logic        seen;
    logic        prev, cur;
    int          ok_cnt;

    clk   = 1'b0;
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    ireq1 = '0;
    dreq1 = '0;
    repeat (3) @(negedge clk);
    check("rst_iresp", 64'(iresp), 64'h0);
    check("rst_dresp_ok", {dresp.addr_ok, dresp.data_ok}, 64'h0);
    check("rst_dresp_data", dresp.data, 64'h0);
    reset = 1'b0;

    // Preload word0 with a full-strobe write.
    dtx(64'h0, 8'hFF, 64'h1111_2222_3333_4444, d64, lat);
    dreq.valid = 1'b0;
    check("w0_lat", 64'(lat), 64'(LAT));
    check("w0_wr_data_zero", d64, 64'h0);

    // Test 1: upper-half ibus read with high address bits ignored.
    ird(64'h8000_0004, d32, lat);
    ireq.valid = 1'b0;
    check("t1_lat", 64'(lat), 64'(LAT));
    check("t1_data", 64'(d32), 64'h1111_2222);
    @(negedge clk);
    check("t1_ok_low", 64'(iresp.data_ok), 64'h0);
    check("t1_data_low", 64'(iresp.data), 64'h0);
    ird(64'h0, d32, lat);
    ireq.valid = 1'b0;
    check("t1_lo_data", 64'(d32), 64'h3333_4444);

    // Test 2: partial-strobe write then read back, including a wrapped alias.
    dtx(64'h10, 8'hFF, 64'h0, d64, lat);
    dreq.valid = 1'b0;
    dtx(64'h10, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, d64, lat);
    dreq.valid = 1'b0;
    check("t2_wr_data_zero", d64, 64'h0);
    dtx(64'h10, 8'h00, 64'h0, d64, lat);
    dreq.valid = 1'b0;
    check("t2_rd", d64, 64'h0000_0000_CCCC_DDDD);
    check("t2_rd_lat", 64'(lat), 64'(LAT));
    dtx(64'h8010, 8'h00, 64'h0, d64, lat);
    dreq.valid = 1'b0;
    check("t2_wrap_rd", d64, 64'h0000_0000_CCCC_DDDD);

    // Test 4: ibus read and dbus write of the same word in the same RESP cycle.
    dtx(64'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, d64, lat);
    dreq.valid = 1'b0;
    @(negedge clk);
    ireq.valid  = 1'b1;
    ireq.addr   = 64'h18;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h18;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hFEDC_BA98_7654_3210;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (iresp.data_ok || dresp.data_ok) begin
        seen = 1'b1;
        check("t4_iok", 64'(iresp.data_ok), 64'h1);
        check("t4_dok", 64'(dresp.data_ok), 64'h1);
        check("t4_old", 64'(iresp.data), 64'h89AB_CDEF);
        break;
      end
    end
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    check("t4_seen", 64'(seen), 64'h1);
    ird(64'h1C, d32, lat);
    ireq.valid = 1'b0;
    check("t4_new_hi", 64'(d32), 64'hFEDC_BA98);
    ird(64'h18, d32, lat);
    ireq.valid = 1'b0;
    check("t4_new_lo", 64'(d32), 64'h7654_3210);

    // Test 5: reset during WAIT of a full write aborts it.
    dtx(64'h20, 8'hFF, 64'h5555_6666_7777_8888, d64, lat);
    dreq.valid = 1'b0;
    @(negedge clk);
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h20;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    check("t5_wait_ok_low", 64'(dresp.data_ok), 64'h0);
    reset      = 1'b1;
    dreq.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("t5_iresp_zero", 64'(iresp), 64'h0);
    check("t5_dresp_ok_zero", {dresp.addr_ok, dresp.data_ok}, 64'h0);
    check("t5_dresp_data_zero", dresp.data, 64'h0);
    ok_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dresp.data_ok) ok_cnt++;
    end
    check("t5_no_ok", 64'(ok_cnt), 64'h0);
    dtx(64'h20, 8'h00, 64'h0, d64, lat);
    dreq.valid = 1'b0;
    check("t5_unchanged", d64, 64'h5555_6666_7777_8888);

    // Test 3: held-valid ibus at LATENCY=1 responds every second cycle.
    @(negedge clk);
    ireq1.valid = 1'b1;
    ireq1.addr  = 64'h0;
    prev = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      cur = iresp1.data_ok;
      check("t3_no_consec", 64'(prev && cur), 64'h0);
`ifndef MEM_STALL_INJECT_EN
      check("t3_pattern", 64'(cur), 64'(k % 2));
`endif
      prev = cur;
    end
    ireq1.valid = 1'b0;

    // Test 6: back-to-back reads, latency bounded and data correct.
    for (int i = 0; i < 40; i++) begin
      ird((i % 2 == 1) ? 64'h4 : 64'h0, d32, lat);
      check("t6_lat_range", 64'((lat >= LAT) && (lat <= LAT + 3)), 64'h1);
      check("t6_data", 64'(d32), (i % 2 == 1) ? 64'h1111_2222 : 64'h3333_4444);
    end
    ireq.valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
